// File: rtl/ddr3_mport_arb_if.sv
// MCB user-port bundle (command, write-data and read-data FIFOs) seen by ddr3_mport_arb.
// master is the arbiter side, slave is the MCB side.
interface ddr3_mport_arb_if #(
    parameter int DATA_W = 128,
    parameter int MASK_W = DATA_W / 8
);
    logic              memc_cmd_en;
    logic [2:0]        memc_cmd_instr;
    logic [5:0]        memc_cmd_bl;
    logic [29:0]       memc_cmd_addr;
    logic              memc_cmd_full;

    logic              memc_wr_en;
    logic [DATA_W-1:0] memc_wr_data;
    logic [MASK_W-1:0] memc_wr_mask;
    logic              memc_wr_full;

    logic              memc_rd_en;
    logic [DATA_W-1:0] memc_rd_data;
    logic              memc_rd_empty;

    modport master (
        output memc_cmd_en, memc_cmd_instr, memc_cmd_bl, memc_cmd_addr,
        input  memc_cmd_full,
        output memc_wr_en, memc_wr_data, memc_wr_mask,
        input  memc_wr_full,
        output memc_rd_en,
        input  memc_rd_data, memc_rd_empty
    );

    modport slave (
        input  memc_cmd_en, memc_cmd_instr, memc_cmd_bl, memc_cmd_addr,
        output memc_cmd_full,
        input  memc_wr_en, memc_wr_data, memc_wr_mask,
        output memc_wr_full,
        input  memc_rd_en,
        output memc_rd_data, memc_rd_empty
    );
endinterface

// File: rtl/ddr3_mport_arb.sv
// Round-robin N-channel arbiter onto one DDR3 MCB user port; a tag FIFO of
// outstanding reads steers each returned word back to the channel that issued it.
module ddr3_mport_arb #(
    parameter int CH_NUM       = 4,
    parameter int DATA_W       = 128,
    parameter int MASK_W       = DATA_W / 8,
    parameter int ADDR_W       = 30,
    parameter int BL_W         = 6,
    parameter int TAG_DEPTHBIT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH_NUM-1:0]        ch_req,
    input  logic [CH_NUM-1:0]        ch_wr,
    input  logic [CH_NUM*ADDR_W-1:0] ch_addr,
    input  logic [CH_NUM*BL_W-1:0]   ch_bl,
    output logic [CH_NUM-1:0]        ch_ack,
    output logic [CH_NUM-1:0]        ch_wreq,
    input  logic [CH_NUM*DATA_W-1:0] ch_wdata,
    input  logic [CH_NUM*MASK_W-1:0] ch_wmask,
    output logic [CH_NUM-1:0]        ch_rvalid,
    output logic [DATA_W-1:0]        ch_rdata,
    ddr3_mport_arb_if.master         memc
);
    localparam int GW        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int TAG_DEPTH = 1 << TAG_DEPTHBIT;
    localparam int CNT_W     = TAG_DEPTHBIT + 1;
    localparam int LOWB      = $clog2(MASK_W);

    typedef enum logic [1:0] {IDLE, WDATA, CMD} state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic [GW-1:0]           last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [BL_W-1:0]         bl_q, bl_d;
    logic                    wr_q, wr_d;
    logic [BL_W-1:0]         wcnt_q, wcnt_d;

    logic [GW-1:0]           tag_ch_q [TAG_DEPTH];
    logic [GW-1:0]           tag_ch_d [TAG_DEPTH];
    logic [BL_W-1:0]         tag_bl_q [TAG_DEPTH];
    logic [BL_W-1:0]         tag_bl_d [TAG_DEPTH];
    logic [TAG_DEPTHBIT-1:0] tag_wptr_q, tag_wptr_d;
    logic [TAG_DEPTHBIT-1:0] tag_rptr_q, tag_rptr_d;
    logic [CNT_W-1:0]        tag_cnt_q, tag_cnt_d;
    logic [BL_W-1:0]         rcnt_q, rcnt_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic [CH_NUM-1:0]       rvalid_q, rvalid_d;

    logic                    tag_full, tag_nonempty;
    logic [CH_NUM-1:0]       eligible, grant_onehot;
    logic                    found;
    logic [GW-1:0]           pick;
    logic [DATA_W-1:0]       wdata_sel;
    logic [MASK_W-1:0]       wmask_sel;
    logic [ADDR_W-1:0]       addr_sel;
    logic [BL_W-1:0]         bl_sel;
    logic                    push, pop;
    logic [GW-1:0]           head_ch;
    logic [BL_W-1:0]         head_bl;

    assign tag_full     = (tag_cnt_q == CNT_W'(TAG_DEPTH));
    assign tag_nonempty = (tag_cnt_q != '0);
    assign eligible     = ch_req & (ch_wr | {CH_NUM{~tag_full}});
    assign grant_onehot = CH_NUM'(1) << grant_q;
    assign head_ch      = tag_ch_q[tag_rptr_q];
    assign head_bl      = tag_bl_q[tag_rptr_q];

    assign memc.memc_wr_en     = (state_q == WDATA) && !memc.memc_wr_full;
    assign memc.memc_cmd_en    = (state_q == CMD) && !memc.memc_cmd_full;
    assign memc.memc_rd_en     = tag_nonempty && !memc.memc_rd_empty;
    assign memc.memc_wr_data   = wdata_sel;
    assign memc.memc_wr_mask   = wmask_sel;
    assign memc.memc_cmd_instr = wr_q ? 3'b000 : 3'b001;
    assign memc.memc_cmd_bl    = 6'(bl_q);
    assign memc.memc_cmd_addr  = 30'({addr_q[ADDR_W-1:LOWB], {LOWB{1'b0}}});

    assign ch_wreq   = memc.memc_wr_en  ? grant_onehot : '0;
    assign ch_ack    = memc.memc_cmd_en ? grant_onehot : '0;
    assign ch_rdata  = rdata_q;
    assign ch_rvalid = rvalid_q;

    assign push = memc.memc_cmd_en && !wr_q;
    assign pop  = memc.memc_rd_en && (rcnt_q == head_bl);

    always_comb begin
        wdata_sel = '0;
        wmask_sel = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (grant_q == GW'(i)) begin
                wdata_sel = ch_wdata[i*DATA_W +: DATA_W];
                wmask_sel = ch_wmask[i*MASK_W +: MASK_W];
            end
        end
    end

    // Search begins just after the last completed grant and wraps around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= CH_NUM; i++) begin
            if (!found && eligible[GW'((int'(last_grant_q) + i) % CH_NUM)]) begin
                found = 1'b1;
                pick  = GW'((int'(last_grant_q) + i) % CH_NUM);
            end
        end
        addr_sel = '0;
        bl_sel   = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (pick == GW'(i)) begin
                addr_sel = ch_addr[i*ADDR_W +: ADDR_W];
                bl_sel   = ch_bl[i*BL_W +: BL_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        bl_d         = bl_q;
        wr_d         = wr_q;
        wcnt_d       = wcnt_q;
        tag_ch_d     = tag_ch_q;
        tag_bl_d     = tag_bl_q;
        tag_wptr_d   = tag_wptr_q;
        tag_rptr_d   = tag_rptr_q;
        tag_cnt_d    = tag_cnt_q;
        rcnt_d       = rcnt_q;
        rdata_d      = rdata_q;
        rvalid_d     = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    addr_d  = addr_sel;
                    bl_d    = bl_sel;
                    wr_d    = ch_wr[pick];
                    state_d = ch_wr[pick] ? WDATA : CMD;
                end
            end
            WDATA: begin
                if (memc.memc_wr_en) begin
                    if (wcnt_q == bl_q) begin
                        wcnt_d  = '0;
                        state_d = CMD;
                    end else begin
                        wcnt_d = wcnt_q + BL_W'(1);
                    end
                end
            end
            CMD: begin
                if (memc.memc_cmd_en) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            tag_ch_d[tag_wptr_q] = grant_q;
            tag_bl_d[tag_wptr_q] = bl_q;
            tag_wptr_d           = tag_wptr_q + TAG_DEPTHBIT'(1);
        end

        // Return path is independent of the request FSM.
        if (memc.memc_rd_en) begin
            rdata_d  = memc.memc_rd_data;
            rvalid_d = CH_NUM'(1) << head_ch;
            rcnt_d   = pop ? '0 : rcnt_q + BL_W'(1);
        end
        if (pop) begin
            tag_rptr_d = tag_rptr_q + TAG_DEPTHBIT'(1);
        end

        case ({push, pop})
            2'b10:   tag_cnt_d = tag_cnt_q + CNT_W'(1);
            2'b01:   tag_cnt_d = tag_cnt_q - CNT_W'(1);
            default: tag_cnt_d = tag_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        tag_ch_q <= tag_ch_d;
        tag_bl_q <= tag_bl_d;
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(CH_NUM - 1);
            addr_q       <= '0;
            bl_q         <= '0;
            wr_q         <= 1'b0;
            wcnt_q       <= '0;
            tag_wptr_q   <= '0;
            tag_rptr_q   <= '0;
            tag_cnt_q    <= '0;
            rcnt_q       <= '0;
            rdata_q      <= '0;
            rvalid_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            bl_q         <= bl_d;
            wr_q         <= wr_d;
            wcnt_q       <= wcnt_d;
            tag_wptr_q   <= tag_wptr_d;
            tag_rptr_q   <= tag_rptr_d;
            tag_cnt_q    <= tag_cnt_d;
            rcnt_q       <= rcnt_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
        end
    end
endmodule

// File: tb/tb_ddr3_mport_arb.sv
// Directed bench for ddr3_mport_arb with a 2-entry tag FIFO and a hand-driven MCB port.
module tb_ddr3_mport_arb;
    localparam int CH  = 4;
    localparam int DW  = 128;
    localparam int MW  = 16;
    localparam int AW  = 30;
    localparam int BW  = 6;
    localparam int TDB = 1;

    logic clk = 1'b0;
    logic rst;
    logic [CH-1:0]    ch_req, ch_wr, ch_ack, ch_wreq, ch_rvalid;
    logic [CH*AW-1:0] ch_addr;
    logic [CH*BW-1:0] ch_bl;
    logic [CH*DW-1:0] ch_wdata;
    logic [CH*MW-1:0] ch_wmask;
    logic [DW-1:0]    ch_rdata;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ddr3_mport_arb_if #(.DATA_W(DW), .MASK_W(MW)) memc_if ();

    ddr3_mport_arb #(
        .CH_NUM(CH), .DATA_W(DW), .MASK_W(MW), .ADDR_W(AW), .BL_W(BW), .TAG_DEPTHBIT(TDB)
    ) dut (
        .clk(clk), .rst(rst),
        .ch_req(ch_req), .ch_wr(ch_wr), .ch_addr(ch_addr), .ch_bl(ch_bl),
        .ch_ack(ch_ack), .ch_wreq(ch_wreq), .ch_wdata(ch_wdata), .ch_wmask(ch_wmask),
        .ch_rvalid(ch_rvalid), .ch_rdata(ch_rdata),
        .memc(memc_if.master)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        ch_req   = '0;
        ch_wr    = '0;
        ch_addr  = '0;
        ch_bl    = '0;
        ch_wdata = '0;
        ch_wmask = '0;
        memc_if.memc_cmd_full = 1'b0;
        memc_if.memc_wr_full  = 1'b0;
        memc_if.memc_rd_empty = 1'b1;
        memc_if.memc_rd_data  = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        memc_if.memc_rd_empty = 1'b0;
        #1;
        vectors++; if (ch_ack !== 4'b0) begin miscompares++; $display("[TB] FAIL reset_ack: got %b expected 0000", ch_ack); end
        vectors++; if (ch_wreq !== 4'b0) begin miscompares++; $display("[TB] FAIL reset_wreq: got %b expected 0000", ch_wreq); end
        vectors++; if (ch_rvalid !== 4'b0) begin miscompares++; $display("[TB] FAIL reset_rvalid: got %b expected 0000", ch_rvalid); end
        vectors++; if (memc_if.memc_cmd_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cmd_en: got %b expected 0", memc_if.memc_cmd_en); end
        vectors++; if (memc_if.memc_wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wr_en: got %b expected 0", memc_if.memc_wr_en); end
        vectors++; if (memc_if.memc_rd_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rd_en: got %b expected 0", memc_if.memc_rd_en); end
        vectors++; if (ch_rdata !== '0) begin miscompares++; $display("[TB] FAIL reset_rdata: got %h expected 0", ch_rdata); end
        memc_if.memc_rd_empty = 1'b1;
    endtask

    task automatic test_single_read();
        logic [DW-1:0] w;
        do_reset();
        ch_addr[2*AW +: AW] = 30'h0000_1234;
        ch_bl[2*BW +: BW]   = 6'd3;
        ch_req = 4'b0100;
        tick();
        vectors++; if (ch_ack !== 4'b0100) begin miscompares++; $display("[TB] FAIL rd_ack: got %b expected 0100", ch_ack); end
        vectors++; if (memc_if.memc_cmd_en !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_cmd_en: got %b expected 1", memc_if.memc_cmd_en); end
        vectors++; if (memc_if.memc_cmd_addr !== 30'h0000_1230) begin miscompares++; $display("[TB] FAIL rd_addr: got %h expected 00001230", memc_if.memc_cmd_addr); end
        vectors++; if (memc_if.memc_cmd_instr !== 3'b001) begin miscompares++; $display("[TB] FAIL rd_instr: got %b expected 001", memc_if.memc_cmd_instr); end
        vectors++; if (memc_if.memc_cmd_bl !== 6'd3) begin miscompares++; $display("[TB] FAIL rd_bl: got %0d expected 3", memc_if.memc_cmd_bl); end
        ch_req = '0;
        tick();
        vectors++; if (ch_ack !== 4'b0) begin miscompares++; $display("[TB] FAIL rd_ack_single: got %b expected 0000", ch_ack); end
        memc_if.memc_rd_empty = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w = DW'(32'hD000_0000 + 32'(i));
            memc_if.memc_rd_data = w;
            #1;
            vectors++; if (memc_if.memc_rd_en !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_en_word%0d: got %b expected 1", i, memc_if.memc_rd_en); end
            tick();
            vectors++; if (ch_rvalid !== 4'b0100) begin miscompares++; $display("[TB] FAIL rd_rvalid_word%0d: got %b expected 0100", i, ch_rvalid); end
            vectors++; if (ch_rdata !== w) begin miscompares++; $display("[TB] FAIL rd_rdata_word%0d: got %h expected %h", i, ch_rdata, w); end
        end
        vectors++; if (memc_if.memc_rd_en !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_en_after_pop: got %b expected 0", memc_if.memc_rd_en); end
        memc_if.memc_rd_empty = 1'b1;
        tick();
        vectors++; if (ch_rvalid !== 4'b0) begin miscompares++; $display("[TB] FAIL rd_rvalid_end: got %b expected 0000", ch_rvalid); end
    endtask

    task automatic test_single_write();
        int widx;
        int pulses;
        logic exp_en;
        logic [DW-1:0] w;
        do_reset();
        ch_wr = 4'b0001;
        ch_addr[0 +: AW] = 30'h0000_0ABC;
        ch_bl[0 +: BW]   = 6'd7;
        ch_wmask = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h000F};
        ch_wdata = {DW'(32'h3333_3333), DW'(32'h2222_2222), DW'(32'h1111_1111), DW'(32'hA000_0000)};
        widx   = 0;
        pulses = 0;
        ch_req = 4'b0001;
        tick();
        for (int c = 0; c < 10; c++) begin
            memc_if.memc_wr_full = (c == 3 || c == 4);
            w = DW'(32'hA000_0000 + 32'(widx));
            ch_wdata[0 +: DW] = w;
            #1;
            exp_en = !(c == 3 || c == 4);
            if (memc_if.memc_wr_en === 1'b1) pulses++;
            vectors++; if (memc_if.memc_wr_en !== exp_en) begin miscompares++; $display("[TB] FAIL wr_en_c%0d: got %b expected %b", c, memc_if.memc_wr_en, exp_en); end
            vectors++; if (ch_wreq !== {3'b000, exp_en}) begin miscompares++; $display("[TB] FAIL wr_wreq_c%0d: got %b expected %b", c, ch_wreq, {3'b000, exp_en}); end
            vectors++; if (memc_if.memc_cmd_en !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_early_cmd_c%0d: got %b expected 0", c, memc_if.memc_cmd_en); end
            if (exp_en) begin
                vectors++; if (memc_if.memc_wr_data !== w) begin miscompares++; $display("[TB] FAIL wr_data_w%0d: got %h expected %h", widx, memc_if.memc_wr_data, w); end
                widx++;
            end
            if (c == 0) begin
                vectors++; if (memc_if.memc_wr_mask !== 16'h000F) begin miscompares++; $display("[TB] FAIL wr_mask: got %h expected 000f", memc_if.memc_wr_mask); end
            end
            tick();
        end
        memc_if.memc_wr_full  = 1'b0;
        memc_if.memc_cmd_full = 1'b1;
        #1;
        vectors++; if (memc_if.memc_cmd_en !== 1'b0 || ch_ack !== 4'b0) begin miscompares++; $display("[TB] FAIL wr_cmd_stall: got cmd_en=%b ack=%b expected 0/0000", memc_if.memc_cmd_en, ch_ack); end
        vectors++; if (memc_if.memc_wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_extra_word: got %b expected 0", memc_if.memc_wr_en); end
        tick();
        memc_if.memc_cmd_full = 1'b0;
        #1;
        vectors++; if (memc_if.memc_cmd_en !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_cmd_en: got %b expected 1", memc_if.memc_cmd_en); end
        vectors++; if (ch_ack !== 4'b0001) begin miscompares++; $display("[TB] FAIL wr_ack: got %b expected 0001", ch_ack); end
        vectors++; if (memc_if.memc_cmd_instr !== 3'b000) begin miscompares++; $display("[TB] FAIL wr_instr: got %b expected 000", memc_if.memc_cmd_instr); end
        vectors++; if (memc_if.memc_cmd_addr !== 30'h0000_0AB0) begin miscompares++; $display("[TB] FAIL wr_addr: got %h expected 00000ab0", memc_if.memc_cmd_addr); end
        vectors++; if (memc_if.memc_cmd_bl !== 6'd7) begin miscompares++; $display("[TB] FAIL wr_bl: got %0d expected 7", memc_if.memc_cmd_bl); end
        vectors++; if (pulses !== 8) begin miscompares++; $display("[TB] FAIL wr_pulse_count: got %0d expected 8", pulses); end
        ch_req = '0;
        tick();
        vectors++; if (ch_ack !== 4'b0) begin miscompares++; $display("[TB] FAIL wr_ack_single: got %b expected 0000", ch_ack); end
    endtask

    task automatic test_round_robin();
        int n_ack;
        logic [CH-1:0] exp;
        do_reset();
        memc_if.memc_rd_empty = 1'b0;
        ch_req = 4'b1111;
        n_ack  = 0;
        for (int cyc = 0; cyc < 60 && n_ack < 8; cyc++) begin
            tick();
            if (ch_ack !== 4'b0) begin
                exp = 4'(1 << (n_ack % 4));
                vectors++; if (ch_ack !== exp) begin miscompares++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", n_ack, ch_ack, exp); end
                n_ack++;
            end
        end
        vectors++; if (n_ack !== 8) begin miscompares++; $display("[TB] FAIL rr_timeout: got %0d acks expected 8", n_ack); end
        ch_req = '0;
        memc_if.memc_rd_empty = 1'b1;
    endtask

    task automatic test_tag_full();
        int seq [6] = '{0, 1, 0, 1, 1, 1};
        int n_ack;
        logic [CH-1:0] exp;
        logic [CH-1:0] first;
        do_reset();
        ch_wr  = 4'b0010;
        ch_req = 4'b0011;
        n_ack  = 0;
        for (int cyc = 0; cyc < 60 && n_ack < 6; cyc++) begin
            tick();
            if (ch_ack !== 4'b0) begin
                exp = 4'(1 << seq[n_ack]);
                vectors++; if (ch_ack !== exp) begin miscompares++; $display("[TB] FAIL tag_full_grant%0d: got %b expected %b", n_ack, ch_ack, exp); end
                n_ack++;
            end
        end
        vectors++; if (n_ack !== 6) begin miscompares++; $display("[TB] FAIL tag_full_timeout: got %0d acks expected 6", n_ack); end
        memc_if.memc_rd_empty = 1'b0;
        first = '0;
        for (int cyc = 0; cyc < 20 && first == '0; cyc++) begin
            tick();
            first = ch_ack;
        end
        vectors++; if (first !== 4'b0001) begin miscompares++; $display("[TB] FAIL tag_release_grant: got %b expected 0001", first); end
        ch_req = '0;
        memc_if.memc_rd_empty = 1'b1;
    endtask

    task automatic test_interleaved();
        logic [DW-1:0] w;
        do_reset();
        ch_bl[1*BW +: BW] = 6'd0;
        ch_bl[3*BW +: BW] = 6'd2;
        ch_req = 4'b1010;
        tick();
        vectors++; if (ch_ack !== 4'b0010) begin miscompares++; $display("[TB] FAIL il_ack1: got %b expected 0010", ch_ack); end
        ch_req = 4'b1000;
        tick();
        vectors++; if (ch_ack !== 4'b0) begin miscompares++; $display("[TB] FAIL il_idle_gap: got %b expected 0000", ch_ack); end
        tick();
        vectors++; if (ch_ack !== 4'b1000) begin miscompares++; $display("[TB] FAIL il_ack3: got %b expected 1000", ch_ack); end
        memc_if.memc_rd_empty = 1'b0;
        w = DW'(32'hE000_0000);
        memc_if.memc_rd_data = w;
        #1;
        vectors++; if (memc_if.memc_rd_en !== 1'b1 || memc_if.memc_cmd_en !== 1'b1) begin miscompares++; $display("[TB] FAIL il_push_pop: got rd_en=%b cmd_en=%b expected 1/1", memc_if.memc_rd_en, memc_if.memc_cmd_en); end
        ch_req = '0;
        tick();
        vectors++; if (ch_rvalid !== 4'b0010) begin miscompares++; $display("[TB] FAIL il_rvalid_w0: got %b expected 0010", ch_rvalid); end
        vectors++; if (ch_rdata !== w) begin miscompares++; $display("[TB] FAIL il_rdata_w0: got %h expected %h", ch_rdata, w); end
        for (int i = 1; i < 4; i++) begin
            w = DW'(32'hE000_0000 + 32'(i));
            memc_if.memc_rd_data = w;
            #1;
            vectors++; if (memc_if.memc_rd_en !== 1'b1) begin miscompares++; $display("[TB] FAIL il_rd_en_w%0d: got %b expected 1", i, memc_if.memc_rd_en); end
            tick();
            vectors++; if (ch_rvalid !== 4'b1000) begin miscompares++; $display("[TB] FAIL il_rvalid_w%0d: got %b expected 1000", i, ch_rvalid); end
            vectors++; if (ch_rdata !== w) begin miscompares++; $display("[TB] FAIL il_rdata_w%0d: got %h expected %h", i, ch_rdata, w); end
        end
        vectors++; if (memc_if.memc_rd_en !== 1'b0) begin miscompares++; $display("[TB] FAIL il_drained: got %b expected 0", memc_if.memc_rd_en); end
        memc_if.memc_rd_empty = 1'b1;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        ch_req = 4'b0010;
        tick();
        ch_req = '0;
        tick();
        ch_wr = 4'b0100;
        ch_bl[2*BW +: BW] = 6'd7;
        ch_req = 4'b0100;
        tick();
        vectors++; if (memc_if.memc_wr_en !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_burst_started: got %b expected 1", memc_if.memc_wr_en); end
        tick();
        tick();
        rst    = 1'b1;
        ch_req = '0;
        memc_if.memc_rd_empty = 1'b0;
        tick();
        vectors++; if (ch_ack !== 4'b0 || ch_wreq !== 4'b0 || ch_rvalid !== 4'b0) begin miscompares++; $display("[TB] FAIL mid_rst_ch_strobes: got ack=%b wreq=%b rvalid=%b expected all 0", ch_ack, ch_wreq, ch_rvalid); end
        vectors++; if (memc_if.memc_cmd_en !== 1'b0 || memc_if.memc_wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_memc_strobes: got cmd_en=%b wr_en=%b expected 0/0", memc_if.memc_cmd_en, memc_if.memc_wr_en); end
        vectors++; if (memc_if.memc_rd_en !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_tag_empty: got rd_en=%b expected 0", memc_if.memc_rd_en); end
        rst    = 1'b0;
        ch_wr  = '0;
        ch_req = 4'b1001;
        tick();
        vectors++; if (ch_ack !== 4'b0001) begin miscompares++; $display("[TB] FAIL mid_rst_first_grant: got %b expected 0001", ch_ack); end
        vectors++; if (memc_if.memc_rd_en !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_no_stale_tag: got rd_en=%b expected 0", memc_if.memc_rd_en); end
        ch_req = '0;
        memc_if.memc_rd_empty = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_round_robin();
        test_tag_full();
        test_interleaved();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
